// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for load-use, branch, mult/div and dmem-wait hazards
module pipeline_hazard_controller #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_bubble,
    output logic             mem_wb_en,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int MW = $clog2(MD_LATENCY);
    localparam logic [MW-1:0] MD_LOAD = MW'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t        state;
    logic [MW-1:0] md_cnt;
    logic          mem_stall, md_hold, br, lu, hit;

    assign mem_stall = dmem_req & ~dmem_ready;
    assign hit       = id_ex_mem_read & (id_ex_rd != 5'd0) &
                       ((id_ex_rd == id_rs) | (id_uses_rt & (id_ex_rd == id_rt)));
    assign md_hold   = (state == MD_WAIT) ? (md_cnt != '0) : md_start;
    assign br        = (state == RUN) & ~md_start & branch_taken;
    assign lu        = (state == RUN) & ~md_start & ~branch_taken & hit;

    // Reset drives the flush outputs high so nothing leaks through while held
    assign pc_en         = rst_n & ~mem_stall & ~md_hold & ~lu;
    assign if_id_en      = pc_en;
    assign id_ex_en      = rst_n & ~mem_stall & ~md_hold;
    assign ex_mem_en     = rst_n & ~mem_stall;
    assign mem_wb_en     = rst_n & ~mem_stall;
    assign if_id_flush   = ~rst_n | (~mem_stall & br);
    assign id_ex_flush   = ~rst_n | (~mem_stall & (br | lu));
    assign ex_mem_bubble = rst_n & ~mem_stall & md_hold;
    assign md_busy       = rst_n & (state == MD_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            md_cnt       <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (mem_stall) begin
                md_cnt <= (md_cnt != '0) ? md_cnt - 1'b1 : '0;
            end else if (state == RUN && md_start) begin
                state  <= MD_WAIT;
                md_cnt <= MD_LOAD;
            end else if (state == MD_WAIT) begin
                if (md_cnt != '0)
                    md_cnt <= md_cnt - 1'b1;
                else
                    state <= RUN;
            end
            if (!pc_en && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            if (!mem_stall && br && flush_count != CNT_MAX)
                flush_count <= flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: scoreboard bench against a behavioural hazard model
module tb_pipeline_hazard_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, id_ex_rd;
    logic       id_uses_rt, id_ex_mem_read, branch_taken, md_start, dmem_req, dmem_ready;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, ex_mem_bubble, mem_wb_en, md_busy;
    logic [3:0] stall_cycles, flush_count;

    int checks = 0;
    int failures = 0;

    bit m_md;
    int m_cnt, m_stall, m_flush;
    logic [16:0] sb[$];

    pipeline_hazard_controller #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .branch_taken(branch_taken),
        .md_start(md_start), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
        .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .ex_mem_bubble(ex_mem_bubble),
        .mem_wb_en(mem_wb_en), .md_busy(md_busy), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] rd, input logic mr, input logic bt,
                         input logic md, input logic dq, input logic dr);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; id_ex_rd = rd; id_ex_mem_read = mr;
        branch_taken = bt; md_start = md; dmem_req = dq; dmem_ready = dr;
    endtask

    // order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, bubble, mem_wb_en
    task automatic tick(input string tag);
        logic [7:0]  e;
        logic [16:0] exp_w;
        logic        ms, luse;
        #1;
        if (!rst_n) begin
            m_md = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
        end
        ms   = dmem_req && !dmem_ready;
        luse = id_ex_mem_read && id_ex_rd != 0 &&
               (id_ex_rd == id_rs || (id_uses_rt && id_ex_rd == id_rt));
        if (!rst_n)                                        e = 8'b0010_1000;
        else if (ms)                                       e = 8'b0000_0000;
        else if ((m_md && m_cnt > 0) || (!m_md && md_start)) e = 8'b0000_0111;
        else if (m_md)                                     e = 8'b1101_0101;
        else if (branch_taken)                             e = 8'b1111_1101;
        else if (luse)                                     e = 8'b0001_1101;
        else                                               e = 8'b1101_0101;
        sb.push_back({e, rst_n && m_md, 4'(m_stall), 4'(m_flush)});
        exp_w = sb.pop_front();
        check({tag, "/ctl"}, {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                              ex_mem_en, ex_mem_bubble, mem_wb_en, md_busy}, 32'(exp_w[16:8]));
        check({tag, "/stall"}, 32'(stall_cycles), 32'(exp_w[7:4]));
        check({tag, "/flush"}, 32'(flush_count), 32'(exp_w[3:0]));
        @(posedge clk);
        if (rst_n) begin
            if (!e[7] && m_stall < 15) m_stall++;
            if (!ms && !m_md && !md_start && branch_taken && m_flush < 15) m_flush++;
            if (ms) begin
                if (m_cnt > 0) m_cnt--;
            end else if (!m_md && md_start) begin
                m_md = 1; m_cnt = 2;
            end else if (m_md) begin
                if (m_cnt > 0) m_cnt--;
                else m_md = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick("rst");
        tick("rst_hold");
        rst_n = 1'b1;
        tick("idle");
        drive(5, 0, 0, 5, 1, 0, 0, 0, 0); tick("lu_rs");
        drive(5, 0, 0, 5, 0, 0, 0, 0, 0); tick("lu_done");
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0); tick("lu_rd0");
        drive(0, 5, 0, 5, 1, 0, 0, 0, 0); tick("rt_nouse");
        drive(0, 5, 1, 5, 1, 0, 0, 0, 0); tick("rt_use");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (4) tick("md");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("md_after");
        drive(5, 0, 0, 5, 1, 1, 0, 0, 0); tick("br_lu");
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0); tick("ms_br");
        drive(0, 0, 0, 0, 0, 1, 0, 1, 1); tick("br_ready");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick("md2_start");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) tick("md2_ms");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); tick("md2_exit");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("md2_run");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick("md3_start");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("md3_wait");
        #2 rst_n = 1'b0;
        tick("areset");
        rst_n = 1'b1;
        tick("post_rst");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (20) tick("ssat");
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (18) tick("fsat");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline. Sits beside the forwarding logic and resolves the hazards forwarding cannot cover: load-use, taken branch/jump, multi-cycle mult/div occupancy of EX, and data-memory wait.
- Drives per-stage register enables, flushes and bubble inserts.
- Keeps saturating stall and flush performance counters.

Parameters:
- MD_LATENCY, 32: total cycles a mult/div instruction occupies EX, including its first cycle; legal range ≥ 2.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_ex_rd  in  5  destination register of the instruction in EX.
- id_ex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  branch/jump resolved taken in EX.
- md_start  in  1  EX instruction is mult/div.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_en  out  1  ID/EX write enable.
- id_ex_flush  out  1  ID/EX loads bubble.
- ex_mem_en  out  1  EX/MEM write enable.
- ex_mem_bubble  out  1  EX/MEM loads bubble.
- mem_wb_en  out  1  MEM/WB write enable.
- md_busy  out  1  mult/div wait in progress.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.
- flush_count  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN, md counter=0, both perf counters=0.
  - While reset is held: all *_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_bubble=0, md_busy=0.
- FSM states:
  - RUN: normal flow.
  - MD_WAIT: EX held by mult/div.
- Enables/flushes are combinational (Mealy) from state and inputs. State and counters update on posedge clk.
- mem_stall = dmem_req & ~dmem_ready. Highest priority, in any state:
  - all *_en=0, all flush/bubble=0.
  - branch and load-use handling suppressed; they are re-evaluated next cycle because the stage contents are frozen.
  - FSM does not change state. The md counter still decrements but does not go below 0.
- RUN with md_start=1 (and no mem_stall):
  - Load counter with MD_LATENCY-2 and go to MD_WAIT.
  - This cycle: pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1, mem_wb_en=1.
- MD_WAIT, counter≠0: same outputs as above; counter decrements; md_busy=1. md_start is ignored in MD_WAIT.
- MD_WAIT, counter==0 (no mem_stall):
  - All enables=1, ex_mem_bubble=0; result advances to MEM.
  - Go to RUN. md_busy=1 this cycle, 0 after.
- RUN, branch_taken=1 (no mem_stall, no md_start):
  - if_id_flush=1, id_ex_flush=1, all enables=1.
  - Overrides load-use (the dependent instruction is squashed).
  - flush_count increments.
- RUN, load-use: id_ex_mem_read=1, id_ex_rd≠0, and (id_ex_rd==id_rs or (id_uses_rt and id_ex_rd==id_rt)).
  - pc_en=0, if_id_en=0, id_ex_flush=1, remaining enables=1.
  - Exactly one bubble, because the load leaves EX next cycle.
- Default: all enables=1, all flush/bubble=0.
- Priority: mem_stall > MD_WAIT/md_start > branch_taken > load-use.
- stall_cycles increments on every non-reset cycle with pc_en=0; saturates at all-ones.
- flush_count saturates at all-ones.
- Reset asserted mid-MD_WAIT: returns immediately to RUN with counter=0.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs=5 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; the next cycle (id_ex_mem_read=0) returns to all enables=1. With id_ex_rd=0 → no stall.
- rt gating: id_rt=5 matches id_ex_rd=5 with id_uses_rt=0 → no stall; with id_uses_rt=1 → stall.
- Mult/div, MD_LATENCY=4:
  - md_start held 4 cycles → pc_en=0 and ex_mem_bubble=1 for cycles 1–3, all enables=1 in cycle 4.
  - md_busy high cycles 2–4.
  - stall_cycles=3.
- Branch + load-use together: branch_taken=1 with a load-use match → if_id_flush=id_ex_flush=1, pc_en=1, flush_count 0→1.
- Memory wait mid-MD_WAIT: dmem_req=1, dmem_ready=0 for 2 cycles during MD_WAIT → all enables 0; the FSM exits only after dmem_ready=1 and counter==0.
- Reset and saturation:
  - Drop rst_n asynchronously mid-MD_WAIT → state RUN, md_busy=0, counters 0 before the next edge.
  - Preload near saturation via a long stall with CNT_W=4 → stall_cycles holds at 15.
